// File: rtl/pcm_pkg.sv
// Shared PCM types for the audio output path: sample format, I2S frame
// geometry and the serialiser state encoding.
package pcm_pkg;

   typedef logic signed [15:0] sample_t;

   localparam int SLOTS_PER_FRAME = 32;
   localparam int HALF_SLOTS      = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } i2s_tx_state_e;

endpackage

// File: rtl/i2s_tx_fifo.sv
// Small synchronous sample FIFO with first-word-fall-through read data.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module i2s_tx_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic             do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer advance; overflow and underflow requests are ignored.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage write; contents need no reset since empty gates every read.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: buffers filter samples and sends each one in both the
// left and right slot of a 32-bclk frame, MSB first with one bclk delay.
// Optional build macro I2S_TX_UNDERRUN_CNT_EN adds a saturating underrun
// event counter on underrun_cnt_o.
//
//  state | meaning
//  IDLE  | clocks parked low, counters at frame start, waiting for enable
//  RUN   | generating frames continuously
//  DRAIN | enable dropped; finish current frame then return to IDLE
module i2s_tx_serializer
   import pcm_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int CLK_DIV    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic                  enable_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic                  bclk_o,
   output logic                  lrclk_o,
   output logic                  sdata_o,
   output logic                  busy_o,
   output logic                  underrun_o
`ifdef I2S_TX_UNDERRUN_CNT_EN
   ,
   output logic [15:0]           underrun_cnt_o
`endif
);

   localparam int         DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [4:0] LAST_SLOT   = 5'(SLOTS_PER_FRAME - 1);
   localparam logic [4:0] L_LOAD_SLOT = 5'd1;
   localparam logic [4:0] R_LOAD_SLOT = 5'(HALF_SLOTS + 1);

   i2s_tx_state_e         state_q, state_d;
   logic [DIV_W-1:0]      div_cnt_q;
   logic [4:0]            bit_cnt_q, bit_nxt;
   logic                  bclk_q, lrclk_q, sdata_q, underrun_q;
   sample_t               hold_q, shift_q, load_word;
   logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_rdata;
   logic                  div_tc, fall, end_frame;

   assign fifo_push = valid_i && !fifo_full;
   assign ready_o   = !fifo_full;

   i2s_tx_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .push_i   (fifo_push),
      .wdata_i  (data_i),
      .pop_i    (fifo_pop),
      .rdata_o  (fifo_rdata),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty)
   );

   assign div_tc    = (div_cnt_q == DIV_W'(CLK_DIV - 1));
   assign fall      = (state_q != IDLE) && div_tc && bclk_q;
   assign bit_nxt   = bit_cnt_q + 5'd1;
   // The falling edge that would open slot 0 is suppressed when draining.
   assign end_frame = (state_q == DRAIN) && !enable_i && fall &&
                      (bit_cnt_q == LAST_SLOT);
   assign fifo_pop  = fall && !end_frame && (bit_nxt == L_LOAD_SLOT) && !fifo_empty;
   assign load_word = fifo_empty ? '0 : sample_t'(fifo_rdata);

   // State register.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // Next-state logic; a returning enable wins over the end of a drain.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (enable_i) state_d = RUN;
         RUN:     if (!enable_i) state_d = DRAIN;
         DRAIN: begin
            if (enable_i)       state_d = RUN;
            else if (end_frame) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Bit clock divider, slot counter, word select and data shifter.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         div_cnt_q  <= '0;
         bclk_q     <= 1'b0;
         bit_cnt_q  <= LAST_SLOT;
         lrclk_q    <= 1'b0;
         sdata_q    <= 1'b0;
         shift_q    <= '0;
         hold_q     <= '0;
         underrun_q <= 1'b0;
      end else begin
         underrun_q <= 1'b0;
         if (state_q == IDLE || end_frame) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= LAST_SLOT;
            lrclk_q   <= 1'b0;
            sdata_q   <= 1'b0;
            shift_q   <= '0;
         end else if (div_tc) begin
            div_cnt_q <= '0;
            bclk_q    <= ~bclk_q;
            if (bclk_q) begin
               bit_cnt_q <= bit_nxt;
               lrclk_q   <= (bit_nxt >= 5'(HALF_SLOTS));
               if (bit_nxt == L_LOAD_SLOT) begin
                  hold_q     <= load_word;
                  sdata_q    <= load_word[15];
                  shift_q    <= {load_word[14:0], 1'b0};
                  underrun_q <= fifo_empty;
               end else if (bit_nxt == R_LOAD_SLOT) begin
                  sdata_q <= hold_q[15];
                  shift_q <= {hold_q[14:0], 1'b0};
               end else begin
                  sdata_q <= shift_q[15];
                  shift_q <= {shift_q[14:0], 1'b0};
               end
            end
         end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
         end
      end
   end

   assign bclk_o     = bclk_q;
   assign lrclk_o    = lrclk_q;
   assign sdata_o    = sdata_q;
   assign busy_o     = (state_q != IDLE);
   assign underrun_o = underrun_q;

`ifdef I2S_TX_UNDERRUN_CNT_EN
   logic [15:0] underrun_cnt_q;

   // Saturating count of underrun events, cleared only by reset.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni)
         underrun_cnt_q <= '0;
      else if (underrun_q && underrun_cnt_q != 16'hFFFF)
         underrun_cnt_q <= underrun_cnt_q + 16'd1;
   end

   assign underrun_cnt_o = underrun_cnt_q;
`endif

endmodule
